ex_mem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register.
- Consumes the ID/EX register outputs, applies forwarding muxes, and computes the ALU result.
- Registers the result together with the WB and M control fields for the memory stage.
- Contains a multi-cycle iterative multiplier. It drives a stall back to the ID/EX register and upstream stages while a multiply is in flight.

---
 rtl/ex_pkg.sv | 34 +++
 rtl/ex_mem_stage_if.sv | 45 ++++
 rtl/ex_mul_iter.sv | 71 +++++++
 rtl/ex_mem_stage.sv | 168 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared codes and types for the execute stage, its EX/MEM register and the iterative multiplier.
package ex_pkg;

   localparam int EX_DATA_W = 32;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_RTYPE = 2'b10,
      ALU_OR    = 2'b11
   } alu_op_e;

   typedef enum logic [5:0] {
      FN_ADD = 6'b100000,
      FN_SUB = 6'b100010,
      FN_AND = 6'b100100,
      FN_OR  = 6'b100101,
      FN_MUL = 6'b011000
   } funct_e;

   typedef enum logic [1:0] {
      FWD_IDEX = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10,
      FWD_RSVD = 2'b11
   } fwd_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } ex_state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, bundled as one bus.
interface ex_mem_stage_if
   import ex_pkg::*;
#(
   parameter int DATA_W = EX_DATA_W
);
   logic              flush_i;
   logic              valid_i;
   logic [1:0]        WB_i;
   logic [1:0]        M_i;
   logic              ALUSrc_i;
   logic [1:0]        ALUOp_i;
   logic              RegDst_i;
   logic [DATA_W-1:0] RSdata_i;
   logic [DATA_W-1:0] RTdata_i;
   logic [DATA_W-1:0] imm_i;
   logic [4:0]        RTaddr_i;
   logic [4:0]        RDaddr_i;
   logic [1:0]        fwdA_i;
   logic [1:0]        fwdB_i;
   logic [DATA_W-1:0] memFwd_i;
   logic [DATA_W-1:0] wbFwd_i;
   logic              stall_o;
   logic              valid_o;
   logic [1:0]        WB_o;
   logic [1:0]        M_o;
   logic [DATA_W-1:0] ALUres_o;
   logic [DATA_W-1:0] wdata_o;
   logic [4:0]        dst_o;

   modport master (
      output flush_i, valid_i, WB_i, M_i, ALUSrc_i, ALUOp_i, RegDst_i,
             RSdata_i, RTdata_i, imm_i, RTaddr_i, RDaddr_i,
             fwdA_i, fwdB_i, memFwd_i, wbFwd_i,
      input  stall_o, valid_o, WB_o, M_o, ALUres_o, wdata_o, dst_o
   );

   modport slave (
      input  flush_i, valid_i, WB_i, M_i, ALUSrc_i, ALUOp_i, RegDst_i,
             RSdata_i, RTdata_i, imm_i, RTaddr_i, RDaddr_i,
             fwdA_i, fwdB_i, memFwd_i, wbFwd_i,
      output stall_o, valid_o, WB_o, M_o, ALUres_o, wdata_o, dst_o
   );

endinterface

// File: rtl/ex_mul_iter.sv
// Shift-add iterative multiplier: one multiplier bit per cycle, keeps the low DATA_W product bits.
module ex_mul_iter #(
   parameter int DATA_W  = 32,
   parameter int MUL_CYC = DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              done_o,
   output logic [DATA_W-1:0] product_o
);

   localparam int              CNT_W    = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYC - 1);

   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;

   // High during the final iteration; the accumulator holds the product on the next cycle.
   assign done_o    = busy_q && (cnt_q == CNT_LAST);
   assign product_o = acc_q;

   // NOTE: combinational blocks use blocking (=) with every output defaulted first, so no latch is inferred.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (abort_i) begin
         busy_d = 1'b0;
      end else if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
      end else if (busy_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (done_o) busy_d = 1'b0;
      end
   end

   // NOTE: state flops use non-blocking (<=) and take the asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // NOTE: operand and accumulator flops carry no reset; start always loads them before they are read.
   always_ff @(posedge clk_i) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
   end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage (forwarding muxes, ALU) plus the EX/MEM pipeline register.
// Define EX_MUL_EN to add the iterative multiplier (funct 011000) and its stall FSM.
module ex_mem_stage
   import ex_pkg::*;
#(
   parameter int DATA_W = EX_DATA_W
`ifdef EX_MUL_EN
   ,
   parameter int MUL_CYC = DATA_W
`endif
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   ex_mem_stage_if.slave bus
);

   logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_res;
   logic              funct_ok, stall;

   logic              valid_q, valid_d;
   logic [1:0]        wb_q, wb_d;
   logic [1:0]        m_q, m_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [4:0]        dst_q, dst_d;

`ifdef EX_MUL_EN
   logic [DATA_W-1:0] mul_prod;
   logic              is_mul, mul_start, mul_done;
   ex_state_e         state_q, state_d;
`endif

   // Reserved select 11 falls back to the ID/EX operand.
   always_comb begin
      case (fwd_sel_e'(bus.fwdA_i))
         FWD_MEM: op_a = bus.memFwd_i;
         FWD_WB:  op_a = bus.wbFwd_i;
         default: op_a = bus.RSdata_i;
      endcase
      case (fwd_sel_e'(bus.fwdB_i))
         FWD_MEM: fwd_b = bus.memFwd_i;
         FWD_WB:  fwd_b = bus.wbFwd_i;
         default: fwd_b = bus.RTdata_i;
      endcase
      op_b = bus.ALUSrc_i ? bus.imm_i : fwd_b;
   end

   always_comb begin
      alu_res  = '0;
      funct_ok = 1'b1;
`ifdef EX_MUL_EN
      is_mul   = 1'b0;
`endif
      case (alu_op_e'(bus.ALUOp_i))
         ALU_ADD: alu_res = op_a + op_b;
         ALU_SUB: alu_res = op_a - op_b;
         ALU_OR:  alu_res = op_a | op_b;
         default: begin
            case (bus.imm_i[5:0])
               FN_ADD: alu_res = op_a + op_b;
               FN_SUB: alu_res = op_a - op_b;
               FN_AND: alu_res = op_a & op_b;
               FN_OR:  alu_res = op_a | op_b;
`ifdef EX_MUL_EN
               FN_MUL: begin
                  alu_res = mul_prod;
                  is_mul  = 1'b1;
               end
`endif
               default: funct_ok = 1'b0;
            endcase
         end
      endcase
   end

`ifdef EX_MUL_EN
   // Stall starts combinationally on detect; flush always returns to IDLE with stall low.
   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      stall     = 1'b0;
      if (!bus.flush_i) begin
         case (state_q)
            ST_IDLE: begin
               if (rst_n_i && bus.valid_i && is_mul) begin
                  mul_start = 1'b1;
                  stall     = 1'b1;
                  state_d   = ST_MUL;
               end
            end
            ST_MUL: begin
               stall = 1'b1;
               if (mul_done) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   ex_mul_iter #(
      .DATA_W  (DATA_W),
      .MUL_CYC (MUL_CYC)
   ) u_mul (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .start_i   (mul_start),
      .abort_i   (bus.flush_i),
      .a_i       (op_a),
      .b_i       (op_b),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );
`else
   assign stall = 1'b0;
`endif

   // Flush, stall and empty slots all load an all-zero bubble.
   always_comb begin
      valid_d = 1'b0;
      wb_d    = '0;
      m_d     = '0;
      res_d   = '0;
      wdata_d = '0;
      dst_d   = '0;
      if (!bus.flush_i && !stall && bus.valid_i) begin
         valid_d = 1'b1;
         wb_d    = funct_ok ? bus.WB_i : 2'b00;
         m_d     = bus.M_i;
         res_d   = alu_res;
         wdata_d = fwd_b;
         dst_d   = bus.RegDst_i ? bus.RDaddr_i : bus.RTaddr_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= 1'b0;
         wb_q    <= '0;
         m_q     <= '0;
         res_q   <= '0;
         wdata_q <= '0;
         dst_q   <= '0;
      end else begin
         valid_q <= valid_d;
         wb_q    <= wb_d;
         m_q     <= m_d;
         res_q   <= res_d;
         wdata_q <= wdata_d;
         dst_q   <= dst_d;
      end
   end

   assign bus.stall_o  = stall;
   assign bus.valid_o  = valid_q;
   assign bus.WB_o     = wb_q;
   assign bus.M_o      = m_q;
   assign bus.ALUres_o = res_q;
   assign bus.wdata_o  = wdata_q;
   assign bus.dst_o    = dst_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized single-cycle traffic vs a reference model.
module tb_ex_mem_stage;

   localparam int DW      = 32;
   localparam int MUL_CYC = 32;

   typedef struct packed {
      logic          flush;
      logic          valid;
      logic [1:0]    wb;
      logic [1:0]    m;
      logic          alusrc;
      logic [1:0]    aluop;
      logic          regdst;
      logic [DW-1:0] rs;
      logic [DW-1:0] rt;
      logic [DW-1:0] imm;
      logic [4:0]    rt_a;
      logic [4:0]    rd_a;
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic [DW-1:0] memf;
      logic [DW-1:0] wbf;
   } stim_t;

   typedef struct packed {
      logic          valid;
      logic [1:0]    wb;
      logic [1:0]    m;
      logic [DW-1:0] res;
      logic [DW-1:0] wdata;
      logic [4:0]    dst;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   ex_mem_stage_if #(.DATA_W(DW)) bus ();

   ex_mem_stage dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic drive(input stim_t s);
      bus.flush_i  = s.flush;
      bus.valid_i  = s.valid;
      bus.WB_i     = s.wb;
      bus.M_i      = s.m;
      bus.ALUSrc_i = s.alusrc;
      bus.ALUOp_i  = s.aluop;
      bus.RegDst_i = s.regdst;
      bus.RSdata_i = s.rs;
      bus.RTdata_i = s.rt;
      bus.imm_i    = s.imm;
      bus.RTaddr_i = s.rt_a;
      bus.RDaddr_i = s.rd_a;
      bus.fwdA_i   = s.fa;
      bus.fwdB_i   = s.fb;
      bus.memFwd_i = s.memf;
      bus.wbFwd_i  = s.wbf;
   endtask

   function automatic exp_t observe();
      exp_t o;
      o.valid = bus.valid_o;
      o.wb    = bus.WB_o;
      o.m     = bus.M_o;
      o.res   = bus.ALUres_o;
      o.wdata = bus.wdata_o;
      o.dst   = bus.dst_o;
      return o;
   endfunction

   function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] own,
                                          input logic [DW-1:0] memf, input logic [DW-1:0] wbf);
      if (sel == 2'b10) return memf;
      if (sel == 2'b01) return wbf;
      return own;
   endfunction

   // Reference result of one instruction as it should appear in EX/MEM once it completes.
   function automatic exp_t model(input stim_t s);
      exp_t          e;
      logic [DW-1:0] a, bf, b, r;
      logic          ok;
      e = '0;
      if (s.flush || !s.valid) return e;
      a  = pick(s.fa, s.rs, s.memf, s.wbf);
      bf = pick(s.fb, s.rt, s.memf, s.wbf);
      b  = s.alusrc ? s.imm : bf;
      ok = 1'b1;
      r  = '0;
      if (s.aluop == 2'b00)      r = a + b;
      else if (s.aluop == 2'b01) r = a - b;
      else if (s.aluop == 2'b11) r = a | b;
      else begin
         case (s.imm[5:0])
            6'b100000: r = a + b;
            6'b100010: r = a - b;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
`ifdef EX_MUL_EN
            6'b011000: r = DW'(a * b);
`endif
            default:   ok = 1'b0;
         endcase
      end
      e.valid = 1'b1;
      e.wb    = ok ? s.wb : 2'b00;
      e.m     = s.m;
      e.res   = ok ? r : '0;
      e.wdata = bf;
      e.dst   = s.regdst ? s.rd_a : s.rt_a;
      return e;
   endfunction

   task automatic test_reset();
      stim_t s;
      exp_t  got;
      s = '0;
      s.valid = 1'b1; s.aluop = 2'b10; s.imm = 32'h18; s.rs = 32'd3; s.rt = 32'd4; s.wb = 2'b11;
      drive(s);
      #1 rst_n = 1'b0;
      #2;
      got = observe();
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", got); end
      checks++;
      if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall_o); end
      s = '0;
      @(negedge clk);
      drive(s);
      rst_n = 1'b1;
      s.valid = 1'b1; s.wb = 2'b11; s.rs = 32'd1; s.rt = 32'd2; s.rt_a = 5'd4;
      @(negedge clk);
      drive(s);
      @(posedge clk); #1;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.ALUres_o !== 32'd3)
         begin errors++; $display("FAIL reset_release got v=%b res=%h exp v=1 res=3", bus.valid_o, bus.ALUres_o); end
      #3 rst_n = 1'b0;
      #1;
      got = observe();
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_midcycle got %h exp 0", got); end
      @(negedge clk);
      drive('0);
      rst_n = 1'b1;
   endtask

   task automatic test_add_fwd();
      stim_t s;
      exp_t  e, got;
      s = '0;
      s.valid = 1'b1; s.rs = 32'd5; s.memf = 32'd10; s.fa = 2'b10; s.imm = 32'd3;
      s.alusrc = 1'b1; s.aluop = 2'b00; s.wb = 2'b01; s.rt = 32'h55; s.rt_a = 5'd2;
      e = '0;
      e.valid = 1'b1; e.wb = 2'b01; e.res = 32'd13; e.wdata = 32'h55; e.dst = 5'd2;
      @(negedge clk); drive(s);
      @(posedge clk); #1;
      got = observe();
      checks++;
      if (got !== e) begin errors++; $display("FAIL add_fwd got %h exp %h", got, e); end
   endtask

   task automatic test_store();
      stim_t s;
      exp_t  e, got;
      s = '0;
      s.valid = 1'b1; s.fb = 2'b01; s.wbf = 32'hDEADBEEF; s.imm = 32'd4; s.rs = 32'h100;
      s.rt = 32'h12345678; s.alusrc = 1'b1; s.aluop = 2'b00; s.m = 2'b10; s.rt_a = 5'd6;
      e = '0;
      e.valid = 1'b1; e.m = 2'b10; e.res = 32'h104; e.wdata = 32'hDEADBEEF; e.dst = 5'd6;
      @(negedge clk); drive(s);
      @(posedge clk); #1;
      got = observe();
      checks++;
      if (got !== e) begin errors++; $display("FAIL store got %h exp %h", got, e); end
   endtask

   task automatic test_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] prod);
      stim_t s;
      exp_t  e, got;
      s = '0;
      s.valid = 1'b1; s.wb = 2'b01; s.aluop = 2'b10; s.imm = 32'h18; s.regdst = 1'b1;
      s.rd_a = 5'd9; s.rt_a = 5'd3; s.rs = a; s.rt = b;
      e = '0;
      e.valid = 1'b1; e.wdata = b; e.dst = 5'd9;
      @(negedge clk); drive(s);
`ifdef EX_MUL_EN
      begin
         int n = 0;
         for (int i = 0; i < MUL_CYC + 8; i++) begin
            #1;
            if (bus.stall_o !== 1'b1) break;
            n++;
            @(posedge clk); #1;
            checks++;
            if (bus.valid_o !== 1'b0 || bus.WB_o !== 2'b00 || bus.M_o !== 2'b00)
               begin errors++; $display("FAIL mul_bubble cyc %0d got v=%b wb=%b m=%b exp 0", i, bus.valid_o, bus.WB_o, bus.M_o); end
            @(negedge clk);
            bus.fwdA_i = 2'b10; bus.fwdB_i = 2'b01;
            bus.memFwd_i = $urandom; bus.wbFwd_i = $urandom;
         end
         bus.fwdA_i = 2'b00; bus.fwdB_i = 2'b00;
         checks++;
         if (n != MUL_CYC + 1) begin errors++; $display("FAIL mul_stall_len got %0d exp %0d", n, MUL_CYC + 1); end
      end
      e.wb  = 2'b01;
      e.res = prod;
`else
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL mul_nostall got %b exp 0", bus.stall_o); end
      e.wb  = 2'b00;
      e.res = '0;
      if (prod == '1) $display("note: unused product %h", prod);
`endif
      @(posedge clk); #1;
      got = observe();
      checks++;
      if (got !== e) begin errors++; $display("FAIL mul_result got %h exp %h", got, e); end
      @(negedge clk); drive('0);
   endtask

   task automatic test_flush();
      stim_t s, add;
      exp_t  e, got;
      s = '0;
      s.valid = 1'b1; s.wb = 2'b01; s.aluop = 2'b10; s.imm = 32'h18; s.rs = 32'd7; s.rt = 32'd6;
      s.flush = 1'b1;
      @(negedge clk); drive(s);
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_prio_stall got %b exp 0", bus.stall_o); end
      @(posedge clk); #1;
      checks++;
      if ({bus.valid_o, bus.WB_o, bus.M_o} !== 5'b0)
         begin errors++; $display("FAIL flush_bubble got %b exp 0", {bus.valid_o, bus.WB_o, bus.M_o}); end
`ifdef EX_MUL_EN
      s.flush = 1'b0;
      @(negedge clk); drive(s);
      repeat (11) @(negedge clk);
      #1;
      checks++;
      if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL flush_mul_busy got %b exp 1", bus.stall_o); end
      bus.flush_i = 1'b1;
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_mul_stall got %b exp 0", bus.stall_o); end
      @(posedge clk); #1;
      checks++;
      if ({bus.valid_o, bus.WB_o, bus.M_o} !== 5'b0)
         begin errors++; $display("FAIL flush_mul_bubble got %b exp 0", {bus.valid_o, bus.WB_o, bus.M_o}); end
`endif
      add = '0;
      add.valid = 1'b1; add.wb = 2'b10; add.rs = 32'h1111; add.rt = 32'h2222; add.rt_a = 5'd7;
      e = '0;
      e.valid = 1'b1; e.wb = 2'b10; e.res = 32'h3333; e.wdata = 32'h2222; e.dst = 5'd7;
      @(negedge clk); drive(add);
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b exp 0", bus.stall_o); end
      @(posedge clk); #1;
      got = observe();
      checks++;
      if (got !== e) begin errors++; $display("FAIL flush_next_add got %h exp %h", got, e); end
   endtask

   task automatic test_unknown_funct();
      stim_t s;
      exp_t  e, got;
      s = '0;
      s.valid = 1'b1; s.wb = 2'b01; s.aluop = 2'b10; s.imm = 32'h0000_002A;
      s.rs = 32'h0F0F_0001; s.rt = 32'h0000_0777; s.regdst = 1'b1; s.rd_a = 5'd12; s.rt_a = 5'd1;
      e = '0;
      e.valid = 1'b1; e.wdata = 32'h0000_0777; e.dst = 5'd12;
      @(negedge clk); drive(s);
      @(posedge clk); #1;
      got = observe();
      checks++;
      if (got !== e) begin errors++; $display("FAIL unknown_funct got %h exp %h", got, e); end
   endtask

   task automatic test_random();
      logic [5:0] fn_list [5];
      stim_t      s;
      exp_t       e, got;
      logic       bad;
      fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b011000};
      for (int i = 0; i < 300; i++) begin
         s = '0;
         s.flush  = ($urandom_range(9) == 0);
         s.valid  = ($urandom_range(9) != 0);
         s.wb     = 2'($urandom);
         s.m      = 2'($urandom);
         s.alusrc = 1'($urandom);
         s.aluop  = 2'($urandom);
         s.regdst = 1'($urandom);
         s.rs     = $urandom;
         s.rt     = $urandom;
         s.imm    = $urandom;
         s.rt_a   = 5'($urandom);
         s.rd_a   = 5'($urandom);
         s.fa     = 2'($urandom);
         s.fb     = 2'($urandom);
         s.memf   = $urandom;
         s.wbf    = $urandom;
         if ($urandom_range(1) == 1) s.imm[5:0] = fn_list[$urandom_range(4)];
`ifdef EX_MUL_EN
         if (s.aluop == 2'b10 && s.imm[5:0] == 6'b011000) s.imm[5:0] = 6'b100100;
`endif
         e = model(s);
         @(negedge clk); drive(s);
         #1;
         checks++;
         if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rand_stall[%0d] got %b exp 0", i, bus.stall_o); end
         @(posedge clk); #1;
         got = observe();
         if (e.valid) bad = (got !== e);
         else         bad = ({got.valid, got.wb, got.m} !== 5'b0);
         checks++;
         if (bad) begin errors++; $display("FAIL rand_out[%0d] got %h exp %h", i, got, e); end
      end
   endtask

   initial begin
      drive('0);
      test_reset();
      test_add_fwd();
      test_store();
      test_mul(32'd7, 32'd6, 32'd42);
      test_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
      test_flush();
      test_unknown_funct();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
